// File: rtl/trade_order_gen.sv
// Trade logic unit: turns registered buy/sell decisions into single orders on
// a valid/ready egress. It enforces a symmetric net-position limit and a
// post-order cooldown, and counts decisions dropped while busy.
// rst_n asserts asynchronously. Its release is expected to arrive already
// synchronised to clk from the reset tree.
module trade_order_gen #(
  parameter int data_width      = 16,
  parameter int QTY_WIDTH       = 8,
  parameter int ORDER_QTY       = 10,
  parameter int POS_WIDTH       = 16,
  parameter int MAX_POSITION    = 100,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_valid_z,
  input  logic                  buy_signal,
  input  logic                  sell_signal,
  input  logic [data_width-1:0] sig_price,
  output logic                  order_valid,
  input  logic                  order_ready,
  output logic                  order_side,
  output logic [QTY_WIDTH-1:0]  order_qty,
  output logic [data_width-1:0] order_price,
  output logic [POS_WIDTH-1:0]  position,
  output logic                  limit_reject,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;

  localparam int CD_W = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [CD_W-1:0]             CD_LOAD = CD_W'(COOLDOWN_CYCLES);
  localparam logic signed [POS_WIDTH:0]   QTY_EXT = (POS_WIDTH+1)'(ORDER_QTY);
  localparam logic signed [POS_WIDTH:0]   MAX_EXT = (POS_WIDTH+1)'(MAX_POSITION);
  localparam logic signed [POS_WIDTH-1:0] QTY_POS = POS_WIDTH'(ORDER_QTY);
  localparam logic [QTY_WIDTH-1:0]        QTY_OUT = QTY_WIDTH'(ORDER_QTY);

  state_t                       state, state_nxt;
  logic                         buy_req, sell_req, buy_ok, sell_ok;
  logic                         accept, handshake;
  logic signed [POS_WIDTH-1:0]  pos_q;
  logic signed [POS_WIDTH:0]    pos_ext, pos_up, pos_dn;
  logic                         side_q;
  logic [data_width-1:0]        price_q;
  logic [CD_W-1:0]              cd_cnt;
  logic                         reject_q;
  logic [CNT_WIDTH-1:0]         drop_q;

  // Contradictory or unqualified decisions are ignored entirely.
  assign buy_req  = data_valid_z & buy_signal & ~sell_signal;
  assign sell_req = data_valid_z & sell_signal & ~buy_signal;

  // Limit check on the registered position, one bit wider so it cannot wrap.
  assign pos_ext = {pos_q[POS_WIDTH-1], pos_q};
  assign pos_up  = pos_ext + QTY_EXT;
  assign pos_dn  = pos_ext - QTY_EXT;
  assign buy_ok  = (pos_up <= MAX_EXT);
  assign sell_ok = (pos_dn >= -MAX_EXT);

  assign order_valid  = (state == ISSUE);
  assign handshake    = order_valid & order_ready;
  assign order_qty    = order_valid ? QTY_OUT : '0;
  assign order_side   = side_q;
  assign order_price  = price_q;
  assign position     = pos_q;
  assign limit_reject = reject_q;
  assign drop_count   = drop_q;
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; accept marks a decision that becomes an order.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if ((buy_req && buy_ok) || (sell_req && sell_ok)) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) state_nxt = (COOLDOWN_CYCLES > 0) ? COOLDOWN : IDLE;
      end
      COOLDOWN: begin
        // Leaving on the 1 -> 0 step gives exactly COOLDOWN_CYCLES cycles here.
        if (cd_cnt <= CD_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Order payload, position, cooldown counter, reject pulse and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side_q   <= 1'b0;
      price_q  <= '0;
      pos_q    <= '0;
      cd_cnt   <= '0;
      reject_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      reject_q <= (state == IDLE) && ((buy_req && !buy_ok) || (sell_req && !sell_ok));
      if (accept) begin
        side_q  <= buy_req;
        price_q <= sig_price;
      end
      if (handshake) pos_q <= side_q ? (pos_q + QTY_POS) : (pos_q - QTY_POS);
      if (handshake)
        cd_cnt <= CD_LOAD;
      else if ((state == COOLDOWN) && (cd_cnt != '0))
        cd_cnt <= cd_cnt - 1'b1;
      if ((state != IDLE) && (buy_req || sell_req) && !(&drop_q))
        drop_q <= drop_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_trade_order_gen.sv
// Bench for trade_order_gen: scenario tasks with a scoreboard queue of
// expected orders, popped by a monitor on each valid/ready handshake.
module tb_trade_order_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_valid_z, buy_signal, sell_signal;
  logic [15:0] sig_price;
  logic        order_valid, order_ready, order_side;
  logic [7:0]  order_qty;
  logic [15:0] order_price, position, drop_count;
  logic        limit_reject, busy;

  typedef struct {
    logic        side;
    logic [15:0] price;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  trade_order_gen dut (
    .clk(clk), .rst_n(rst_n), .data_valid_z(data_valid_z),
    .buy_signal(buy_signal), .sell_signal(sell_signal), .sig_price(sig_price),
    .order_valid(order_valid), .order_ready(order_ready), .order_side(order_side),
    .order_qty(order_qty), .order_price(order_price), .position(position),
    .limit_reject(limit_reject), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handshake must match the oldest expected order.
  always @(negedge clk) begin
    if (rst_n && order_valid && order_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: order side=%0b price=%h, expected none", order_side, order_price);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (order_side !== e.side || order_price !== e.price || order_qty !== 8'd10) begin
          fails++;
          $display("FAIL sb_order: got side=%0b qty=%0d price=%h, want side=%0b qty=10 price=%h",
                   order_side, order_qty, order_price, e.side, e.price);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic b, input logic s, input logic [15:0] p);
    data_valid_z = dv; buy_signal = b; sell_signal = s; sig_price = p;
  endtask

  task automatic push_exp(input logic side, input logic [15:0] price);
    exp_t e;
    e.side = side; e.price = price;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin tick(); n++; end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL wait_idle: busy=%0b after %0d cycles, want 0", busy, n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; order_ready = 1'b0; drive(0, 0, 0, 16'h0);
    #12;
    tests++;
    if ({order_valid, order_side, order_qty, order_price, position, limit_reject, drop_count, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b side=%0b qty=%0d price=%h pos=%h rej=%0b drop=%0d busy=%0b, want all 0",
               order_valid, order_side, order_qty, order_price, position, limit_reject, drop_count, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || order_valid !== 1'b0) begin fails++; $display("FAIL reset_release: busy=%0b valid=%0b, want 0 0", busy, order_valid); end
  endtask

  task automatic test_basic_buy();
    order_ready = 1'b1;
    drive(1, 1, 0, 16'h0C80);
    push_exp(1'b1, 16'h0C80);
    tick();
    drive(0, 0, 0, 16'h0);
    tests++;
    if (order_valid !== 1'b1 || order_side !== 1'b1 || order_qty !== 8'd10 || order_price !== 16'h0C80) begin
      fails++;
      $display("FAIL buy_latency: valid=%0b side=%0b qty=%0d price=%h, want 1 1 10 0c80", order_valid, order_side, order_qty, order_price);
    end
    tick();
    tests++;
    if (position !== 16'd10 || order_valid !== 1'b0 || order_qty !== 8'd0) begin
      fails++;
      $display("FAIL buy_position: pos=%0d valid=%0b qty=%0d, want 10 0 0", $signed(position), order_valid, order_qty);
    end
    repeat (3) tick();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL cooldown_hold: busy=%0b after 3 cooldown cycles, want 1", busy); end
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL cooldown_exit: busy=%0b after 4 cooldown cycles, want 0", busy); end
  endtask

  task automatic test_backpressure();
    order_ready = 1'b0;
    drive(1, 0, 1, 16'h1234);
    push_exp(1'b0, 16'h1234);
    tick();
    drive(0, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (order_valid !== 1'b1 || order_side !== 1'b0 || order_qty !== 8'd10 ||
          order_price !== 16'h1234 || position !== 16'd10) begin
        fails++;
        $display("FAIL stall_%0d: valid=%0b side=%0b qty=%0d price=%h pos=%0d, want 1 0 10 1234 10",
                 i, order_valid, order_side, order_qty, order_price, $signed(position));
      end
      tick();
    end
    order_ready = 1'b1;
    tick();
    tests++;
    if (position !== 16'd0) begin fails++; $display("FAIL stall_release_pos: pos=%0d, want 0", $signed(position)); end
    wait_idle();
  endtask

  task automatic test_limit();
    order_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 16'h0100 + 16'(i));
      push_exp(1'b1, 16'h0100 + 16'(i));
      tick();
      drive(0, 0, 0, 16'h0);
      tick();
      wait_idle();
    end
    tests++;
    if (position !== 16'd100) begin fails++; $display("FAIL limit_fill: pos=%0d, want 100", $signed(position)); end
    drive(1, 1, 0, 16'h0200);
    tick();
    drive(0, 0, 0, 16'h0);
    tests++;
    if (limit_reject !== 1'b1 || order_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL limit_reject: rej=%0b valid=%0b busy=%0b, want 1 0 0", limit_reject, order_valid, busy);
    end
    tick();
    tests++;
    if (limit_reject !== 1'b0 || position !== 16'd100) begin
      fails++;
      $display("FAIL limit_pulse: rej=%0b pos=%0d, want 0 100", limit_reject, $signed(position));
    end
    drive(1, 0, 1, 16'h0F00);
    push_exp(1'b0, 16'h0F00);
    tick();
    drive(0, 0, 0, 16'h0);
    tick();
    tests++;
    if (position !== 16'd90) begin fails++; $display("FAIL limit_sell: pos=%0d, want 90", $signed(position)); end
    wait_idle();
  endtask

  task automatic test_busy_drop();
    order_ready = 1'b0;
    drive(1, 0, 1, 16'h1111);
    push_exp(1'b0, 16'h1111);
    tick();
    tests++;
    if (order_valid !== 1'b1) begin fails++; $display("FAIL drop_issue: valid=%0b, want 1", order_valid); end
    order_ready = 1'b1;
    repeat (5) tick();
    tests++;
    if (drop_count !== 16'd5 || busy !== 1'b0 || position !== 16'd80) begin
      fails++;
      $display("FAIL drop_count: drop=%0d busy=%0b pos=%0d, want 5 0 80", drop_count, busy, $signed(position));
    end
    sig_price = 16'h2222;
    push_exp(1'b0, 16'h2222);
    tick();
    drive(0, 0, 0, 16'h0);
    tests++;
    if (order_valid !== 1'b1 || order_price !== 16'h2222) begin
      fails++;
      $display("FAIL drop_first_idle: valid=%0b price=%h, want 1 2222", order_valid, order_price);
    end
    tick();
    tests++;
    if (position !== 16'd70) begin fails++; $display("FAIL drop_after_pos: pos=%0d, want 70", $signed(position)); end
    wait_idle();
    tests++;
    if (drop_count !== 16'd5) begin fails++; $display("FAIL drop_final: drop=%0d, want 5", drop_count); end
  endtask

  task automatic test_invalid();
    drive(1, 1, 1, 16'h3333);
    tick();
    tests++;
    if (order_valid !== 1'b0 || busy !== 1'b0 || limit_reject !== 1'b0 || drop_count !== 16'd5) begin
      fails++;
      $display("FAIL both_set: valid=%0b busy=%0b rej=%0b drop=%0d, want 0 0 0 5", order_valid, busy, limit_reject, drop_count);
    end
    drive(0, 1, 0, 16'h3333);
    tick();
    tests++;
    if (order_valid !== 1'b0 || busy !== 1'b0 || limit_reject !== 1'b0 || drop_count !== 16'd5) begin
      fails++;
      $display("FAIL no_valid: valid=%0b busy=%0b rej=%0b drop=%0d, want 0 0 0 5", order_valid, busy, limit_reject, drop_count);
    end
    drive(0, 0, 0, 16'h0);
  endtask

  task automatic test_reset_mid();
    order_ready = 1'b0;
    drive(1, 1, 0, 16'h4444);
    push_exp(1'b1, 16'h4444);
    tick();
    drive(0, 0, 0, 16'h0);
    tests++;
    if (order_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_issue: valid=%0b, want 1", order_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (order_valid !== 1'b0 || order_qty !== 8'd0 || position !== 16'd0 || drop_count !== 16'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: valid=%0b qty=%0d pos=%0d drop=%0d busy=%0b, want 0 0 0 0 0",
               order_valid, order_qty, $signed(position), drop_count, busy);
    end
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || position !== 16'd0) begin fails++; $display("FAIL rst_release: busy=%0b pos=%0d, want 0 0", busy, $signed(position)); end
    order_ready = 1'b1;
    drive(1, 1, 0, 16'h5555);
    push_exp(1'b1, 16'h5555);
    tick();
    drive(0, 0, 0, 16'h0);
    tests++;
    if (order_valid !== 1'b1) begin fails++; $display("FAIL rst_reissue: valid=%0b, want 1", order_valid); end
    tick();
    tests++;
    if (position !== 16'd10) begin fails++; $display("FAIL rst_reissue_pos: pos=%0d, want 10", $signed(position)); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_basic_buy();
    test_backpressure();
    test_limit();
    test_busy_drop();
    test_invalid();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL sb_leftover: %0d expected orders never seen, want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
